// File: rtl/i2c_apb_master.sv
// Command-driven APB master feeding the I2C controller's APB slave port.
// Optional polling reads are enabled by defining I2C_APB_POLL_EN.
module i2c_apb_master #(
    parameter int TIMEOUT  = 255,
    parameter int POLL_MAX = 1024,
    parameter int POLL_GAP = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [31:0] cmd_mask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] rsp_cnt,
    output logic        apb_sel,
    output logic        apb_en,
    output logic        apb_write,
    output logic [31:0] apb_addr,
    output logic [31:0] apb_wdata,
    input  logic        apb_ready,
    input  logic [31:0] apb_rdata,
    output logic        busy
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        OP_WR   = 2'b00,
        OP_RD   = 2'b01,
        OP_POLL = 2'b10,
        OP_RSV  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
`ifdef I2C_APB_POLL_EN
        , S_GAP
`endif
    } state_e;

    state_e            state, state_next;
    op_e               op_q;
    logic [31:0]       addr_q, wdata_q;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              cmd_legal, access_tmo;
    logic [15:0]       cnt_inc;
    logic              poll_retry;

`ifdef I2C_APB_POLL_EN
    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LIMIT  = GAP_W'(POLL_GAP);
    localparam logic [15:0]      POLL_LIMIT = 16'(POLL_MAX);

    logic [31:0]      mask_q;
    logic [GAP_W-1:0] gap_cnt;
    logic             poll_match;

    assign poll_match = ((apb_rdata ^ wdata_q) & mask_q) == '0;
    assign poll_retry = (op_q == OP_POLL) && !poll_match && (cnt_inc < POLL_LIMIT);
    assign cmd_legal  = (cmd_op != OP_RSV);
`else
    assign poll_retry = 1'b0;
    assign cmd_legal  = (cmd_op == OP_WR) || (cmd_op == OP_RD);
`endif

    assign cnt_inc    = (rsp_cnt == 16'hFFFF) ? rsp_cnt : rsp_cnt + 16'd1;
    assign access_tmo = (state == S_ACCESS) && !apb_ready && (TIMEOUT != 0) && (tmo_cnt == TMO_LIMIT);

    // Bus and handshake outputs decode straight from state so they change only on clock edges.
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign apb_sel   = (state == S_SETUP) || (state == S_ACCESS);
    assign apb_en    = (state == S_ACCESS);
    assign apb_write = apb_sel && (op_q == OP_WR);
    assign apb_addr  = addr_q;
    assign apb_wdata = (op_q == OP_WR) ? wdata_q : '0;

    // NOTE: every output of this block is assigned a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (cmd_valid) state_next = cmd_legal ? S_SETUP : S_RESP;
            S_SETUP:  state_next = S_ACCESS;
            S_ACCESS: begin
                if (access_tmo) begin
                    state_next = S_RESP;
                end else if (apb_ready) begin
`ifdef I2C_APB_POLL_EN
                    if (poll_retry) state_next = (POLL_GAP == 0) ? S_SETUP : S_GAP;
                    else            state_next = S_RESP;
`else
                    state_next = S_RESP;
`endif
                end
            end
`ifdef I2C_APB_POLL_EN
            S_GAP:    if (gap_cnt == GAP_LIMIT) state_next = S_SETUP;
`endif
            S_RESP:   if (rsp_ready) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Free-running while in the state, reloaded to 1 otherwise; each state exits at its limit.
    always_ff @(posedge clk) begin
        if (rst)                    tmo_cnt <= '0;
        else if (state == S_ACCESS) tmo_cnt <= tmo_cnt + 1'b1;
        else                        tmo_cnt <= TMO_W'(1);
    end

`ifdef I2C_APB_POLL_EN
    always_ff @(posedge clk) begin
        if (rst)                 gap_cnt <= '0;
        else if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;
        else                     gap_cnt <= GAP_W'(1);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= OP_WR;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_cnt   <= '0;
`ifdef I2C_APB_POLL_EN
            mask_q    <= '0;
`endif
        end else if (state == S_IDLE && cmd_valid) begin
            op_q      <= op_e'(cmd_op);
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            rsp_rdata <= '0;
            rsp_err   <= !cmd_legal;
            rsp_cnt   <= '0;
`ifdef I2C_APB_POLL_EN
            mask_q    <= cmd_mask;
`endif
        end else if (access_tmo) begin
            rsp_cnt   <= cnt_inc;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
        end else if (state == S_ACCESS && apb_ready) begin
            rsp_cnt <= cnt_inc;
            if (op_q != OP_WR) rsp_rdata <= apb_rdata;
`ifdef I2C_APB_POLL_EN
            // A non-matching poll read that is not retried means attempts ran out.
            rsp_err <= (op_q == OP_POLL) && !poll_match && !poll_retry;
`else
            rsp_err <= 1'b0;
`endif
        end
    end

endmodule
